// File: rtl/uart_pkg.sv
// Shared definitions for the framed PISO transmitter: parity codes, FSM states, data-length decode.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

    // Parity selection codes; 2'b11 is treated the same as PAR_NONE.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Framing FSM states.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // data_len code 00..11 selects 5..8 bits, never more than the datapath width.
    function automatic int unsigned len_from_code(input logic [1:0] code,
                                                  input int unsigned max_w);
        int unsigned w;
        w = 32'd5 + {30'd0, code};
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word visible combinationally on rd_dat.
// Latency: a word pushed at edge E is visible at the head after E (readable from E+1).
// Backpressure: pushes while full and pops while empty are ignored; full/empty from pre-edge state.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         baud_clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok;
    logic         pop_ok;

    // Same index with differing wrap bits means every slot is occupied.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_dat  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; natural wrap of the AW+1 bit counters gives modulo-DEPTH indexing.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; clearing them empties the FIFO.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge baud_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Buffers host words and shifts each out LSB-first as start/data/parity/stop frames.
// Latency: word pushed at edge E starts its start bit at E+1 at the earliest; one bit per baud_clk.
// Backpressure: fifo_full reported; pushes while full are dropped and flagged by a 1-cycle overflow.
module piso_frame_tx
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              baud_clk,
    input  logic              reset_n,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        data_len,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic              data_tx,
    output logic              active_flag,
    output logic              done_flag,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] fifo_rd_dat;
    logic              fifo_empty;
    logic              fifo_full_w;
    logic              pop;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  nbits_q, nbits_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              two_stop_q, two_stop_d;
    logic              tx_q, tx_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [CNT_W-1:0]  launch_nbits;
    logic              launch_ones;
    logic              last_stop;
    logic              do_launch;
    logic [CNT_W-1:0]  stop_target;

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .push     (send),
        .wr_dat   (data_in),
        .pop      (pop),
        .rd_dat   (fifo_rd_dat),
        .full     (fifo_full_w),
        .empty    (fifo_empty)
    );

    // Per-frame configuration sampled from the live inputs at the moment of launch.
    always_comb begin
        launch_nbits = CNT_W'(len_from_code(data_len, DATA_W));
        launch_ones  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(launch_nbits)) launch_ones = launch_ones ^ fifo_rd_dat[i];
        end
    end

    assign stop_target = two_stop_q ? CNT_W'(2) : CNT_W'(1);
    assign last_stop   = (state_q == ST_STOP) && (bit_cnt_q == stop_target);
    // Launch from idle, or straight out of the final stop bit so frames run back-to-back.
    assign do_launch   = !fifo_empty && ((state_q == ST_IDLE) || last_stop);
    assign pop         = do_launch;

    // Framing FSM and shifter; tx_d is the bit that will be on the line next cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        active_d   = active_q;
        done_d     = 1'b0;
        ovf_d      = send && fifo_full_w;

        case (state_q)
            ST_IDLE: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
            end
            ST_START: begin
                state_d   = ST_DATA;
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = CNT_W'(1);
            end
            ST_DATA: begin
                if (bit_cnt_q == nbits_q) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = CNT_W'(1);
                    end
                end else begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                state_d   = ST_STOP;
                tx_d      = 1'b1;
                bit_cnt_d = CNT_W'(1);
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (last_stop) begin
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_d     = 1'b1;
                active_d = 1'b0;
            end
        endcase

        if (do_launch) begin
            state_d    = ST_START;
            shift_d    = fifo_rd_dat;
            nbits_d    = launch_nbits;
            par_en_d   = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
            par_bit_d  = (parity_type == PAR_ODD) ? ~launch_ones : launch_ones;
            two_stop_d = stop_bits;
            tx_d       = 1'b0;
            active_d   = 1'b1;
        end
    end

    // State registers; reset abandons any frame and parks the line high.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            nbits_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data_tx     = tx_q;
    assign active_flag = active_q;
    assign done_flag   = done_q;
    assign overflow    = ovf_q;
    assign fifo_full   = fifo_full_w;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: directed and random frames checked against a bit-stream model.
// Latency: stream captured whenever active_flag is high, compared per phase.
// Backpressure: overflow and fifo_full observed and counted per phase.
module tb_piso_frame_tx;

    logic       baud_clk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       send     = 1'b0;
    logic [7:0] data_in  = '0;
    logic [1:0] data_len = '0;
    logic [1:0] parity_type = '0;
    logic       stop_bits = 1'b0;
    logic       data_tx, active_flag, done_flag, fifo_full, overflow;

    piso_frame_tx #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .send        (send),
        .data_in     (data_in),
        .data_len    (data_len),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_tx     (data_tx),
        .active_flag (active_flag),
        .done_flag   (done_flag),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    always #5 baud_clk = ~baud_clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    bit   got_q[$];
    bit   exp_q[$];
    logic [7:0] push_q[$];
    int   done_cnt, ovf_cnt, act_rise, full_seen;
    logic act_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: records every bit while a frame is on the line, counts pulses.
    always @(negedge baud_clk) begin
        if (reset_n) begin
            if (active_flag) got_q.push_back(data_tx);
            else chk("idle_line_high", {31'd0, data_tx}, 32'd1);
            if (done_flag) done_cnt++;
            if (overflow) ovf_cnt++;
            if (fifo_full) full_seen++;
            if (active_flag && !act_prev) act_rise++;
        end
        act_prev <= active_flag;
    end

    // Reference: a frame is start 0, N data bits LSB-first, optional parity, S stop ones.
    task automatic add_frame(input logic [7:0] w, input logic [1:0] len,
                             input logic [1:0] pt, input logic sb);
        int n;
        int ones;
        n = 5 + int'(len);
        if (n > 8) n = 8;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pt == 2'b01) exp_q.push_back((ones % 2) == 0);
        else if (pt == 2'b10) exp_q.push_back((ones % 2) == 1);
        exp_q.push_back(1'b1);
        if (sb) exp_q.push_back(1'b1);
    endtask

    task automatic start_phase();
        @(posedge baud_clk);
        #1;
        got_q.delete();
        exp_q.delete();
        push_q.delete();
        done_cnt = 0; ovf_cnt = 0; act_rise = 0; full_seen = 0;
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic [1:0] pt, input logic sb);
        data_len = len; parity_type = pt; stop_bits = sb;
    endtask

    // Pushes every word in push_q on consecutive edges.
    task automatic push_burst();
        foreach (push_q[i]) begin
            @(negedge baud_clk);
            send = 1'b1;
            data_in = push_q[i];
        end
        @(negedge baud_clk);
        send = 1'b0;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge baud_clk);
    endtask

    task automatic check_phase(input string tag, input int frames, input int ovf, input int rises);
        int first_bad;
        #1;
        first_bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (first_bad < 0 && got_q[i] !== exp_q[i]) first_bad = i;
        end
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        chk({tag, "_first_bad_bit"}, first_bad, -1);
        chk({tag, "_done"}, done_cnt, frames);
        chk({tag, "_ovf"}, ovf_cnt, ovf);
        chk({tag, "_active_rises"}, act_rise, rises);
    endtask

    initial begin
        logic [1:0] rl, rp;
        logic       rs;
        int         nw;

        // Reset state
        #12;
        chk("rst_tx", {31'd0, data_tx}, 32'd1);
        chk("rst_active", {31'd0, active_flag}, 32'd0);
        chk("rst_done", {31'd0, done_flag}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        @(negedge baud_clk);
        reset_n = 1'b1;

        // 8 bits, no parity, one stop
        start_phase(); set_cfg(2'b11, 2'b00, 1'b0);
        push_q.push_back(8'h4A); add_frame(8'h4A, 2'b11, 2'b00, 1'b0);
        push_burst(); settle(20);
        check_phase("t1_8n1", 1, 0, 1);

        // Odd parity, two stops
        start_phase(); set_cfg(2'b11, 2'b01, 1'b1);
        push_q.push_back(8'h5A); add_frame(8'h5A, 2'b11, 2'b01, 1'b1);
        push_burst(); settle(20);
        check_phase("t2_8o2", 1, 0, 1);

        // Even parity, two stops
        start_phase(); set_cfg(2'b11, 2'b10, 1'b1);
        push_q.push_back(8'h5A); add_frame(8'h5A, 2'b11, 2'b10, 1'b1);
        push_burst(); settle(20);
        check_phase("t2_8e2", 1, 0, 1);

        // 7 bits even: bit 7 neither sent nor counted in parity
        start_phase(); set_cfg(2'b10, 2'b10, 1'b0);
        push_q.push_back(8'h5A); add_frame(8'h5A, 2'b10, 2'b10, 1'b0);
        push_burst(); settle(20);
        check_phase("t3_7e1", 1, 0, 1);

        // Three back-to-back frames
        start_phase(); set_cfg(2'b11, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_q.push_back(8'($urandom));
            add_frame(push_q[i], 2'b11, 2'b01, 1'b1);
        end
        push_burst(); settle(3 * 12 + 20);
        check_phase("t4_b2b", 3, 0, 1);

        // Six pushes: one launched, four buffered, one dropped
        start_phase(); set_cfg(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push_q.push_back(8'(8'h10 + i));
            if (i < 5) add_frame(push_q[i], 2'b11, 2'b00, 1'b0);
        end
        push_burst(); settle(5 * 10 + 20);
        check_phase("t5_overflow", 5, 1, 1);
        chk("t5_full_seen", {31'd0, full_seen > 0}, 32'd1);

        // Config change mid-frame is ignored by the frame in flight
        start_phase(); set_cfg(2'b11, 2'b10, 1'b1);
        push_q.push_back(8'hC3); add_frame(8'hC3, 2'b11, 2'b10, 1'b1);
        push_burst(); settle(3);
        set_cfg(2'b00, 2'b01, 1'b0);
        settle(20);
        check_phase("t_cfg_hold", 1, 0, 1);

        // Random configurations and bursts (never deep enough to overflow)
        for (int k = 0; k < 8; k++) begin
            start_phase();
            rl = 2'($urandom); rp = 2'($urandom); rs = 1'($urandom);
            nw = $urandom_range(1, 4);
            set_cfg(rl, rp, rs);
            for (int i = 0; i < nw; i++) begin
                push_q.push_back(8'($urandom));
                add_frame(push_q[i], rl, rp, rs);
            end
            push_burst(); settle(nw * 12 + 20);
            check_phase($sformatf("rand%0d", k), nw, 0, 1);
        end

        // Reset mid-DATA
        start_phase(); set_cfg(2'b11, 2'b00, 1'b0);
        push_q.push_back(8'hA5);
        push_burst(); settle(3);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_tx", {31'd0, data_tx}, 32'd1);
        chk("t6_rst_active", {31'd0, active_flag}, 32'd0);
        chk("t6_rst_done", {31'd0, done_flag}, 32'd0);
        chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("t6_rst_full", {31'd0, fifo_full}, 32'd0);
        @(negedge baud_clk);
        @(negedge baud_clk);
        reset_n = 1'b1;
        start_phase();
        settle(30);
        check_phase("t6_after_rst", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
